level_crossing_ctrl: RTL and testbench
======================================

Name: level_crossing_ctrl

Overview:
Central sequencer for the automatic level crossing. Consumes the per-axle direction pulses from the entry and exit wheel-detector FSMs and keeps a net axle count for the protected section. It runs the warning lamps and barrier motor (warn, lower, hold, raise), supervises the limit switches and motor timeouts, and latches a fail-safe fault state. It sits between the wheel detectors and the lamp/motor drivers.

Parameters:
CW, 8, axle counter width (max count 2^CW-1)
WARN_CYCLES, 500, cycles lamps run before barrier lowering starts (>=1)
HOLD_CYCLES, 1000, cycles section must stay empty before raising (>=1)
MOTOR_TIMEOUT, 2000, max cycles for barrier travel before fault (>=1)

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  synchronous, active-high reset
in_axle  in  1  one-cycle pulse: axle entered section (entry detector a2b)
in_axle_rev  in  1  one-cycle pulse: axle backed out through entry (entry detector b2a)
out_axle  in  1  one-cycle pulse: axle left section (exit detector a2b)
gate_down_lim  in  1  barrier fully-down limit switch
gate_up_lim  in  1  barrier fully-up limit switch
fault_clr  in  1  one-cycle maintenance clear request
lamp_on  out  1  warning lamps active
motor_down  out  1  drive barrier down
motor_up  out  1  drive barrier up
gate_closed  out  1  state is CLOSED or HOLD
fault  out  1  state is FAULT
axle_count  out  CW  net axles in section

Behaviour:
- Interface: one clock (Clk). Reset is synchronous and active-high. Reset forces state IDLE, axle_count 0, timer 0, all outputs 0.
- All outputs decode from registered state and count only. There is no combinational path from input to output.
- Counter: next = count + in_axle - out_axle - in_axle_rev, evaluated as a signed net.
  - A net change that would exceed 2^CW-1 holds the count at max and forces FAULT.
  - A net change that would go below 0 clamps the count to 0 and forces FAULT.
  - Counter updates continue in every state, including FAULT.
- Timer (down-counter): loaded with N-1 on state entry. Expires on the cycle it reads 0.
- States and transitions (the evaluation uses registered count):
  - IDLE: all outputs 0. count!=0 -> WARN, load WARN_CYCLES.
  - WARN: lamp_on=1. Timer expiry -> LOWER, load MOTOR_TIMEOUT. Exactly WARN_CYCLES cycles elapse in WARN, even if count returns to 0 meanwhile.
  - LOWER: lamp_on=1, motor_down=1. gate_down_lim -> CLOSED. Timer expiry -> FAULT.
  - CLOSED: lamp_on=1, gate_closed=1. count==0 -> HOLD, load HOLD_CYCLES.
  - HOLD: lamp_on=1, gate_closed=1. count!=0 -> CLOSED. Timer expiry -> RAISE, load MOTOR_TIMEOUT.
  - RAISE: lamp_on=1, motor_up=1. count!=0 -> LOWER, load MOTOR_TIMEOUT (immediate reversal, no re-warn). gate_up_lim -> IDLE. Timer expiry -> FAULT.
  - FAULT: lamp_on=1, fault=1, motors off. fault_clr -> LOWER if count!=0, else RAISE. Either target loads MOTOR_TIMEOUT.
- gate_down_lim and gate_up_lim both high in any non-FAULT state -> FAULT (sensor fault). This condition has priority over all other transitions.
- Priority within a state: limit-switch conflict > counter over/underflow > listed transitions in order written.
- motor_down and motor_up are never high in the same cycle.
- Reset mid-operation: returns to IDLE with count 0 regardless of barrier position. The next entry pulse restarts the full warning sequence.

Decomposition:
- Shared package/include lc_pkg holds the 3-bit state encodings (IDLE, WARN, LOWER, CLOSED, HOLD, RAISE, FAULT) and a width helper for the timer (clog2 of the largest cycle parameter).
- One sub-module, lc_timer: load value, load strobe, decrement, done flag. It is instantiated once and shared by all timed states.

Test Plan:
- Normal pass, with WARN=4, HOLD=3, TIMEOUT=10: in_axle pulse at edge k. Then count=1 after edge k, lamp_on after k+1, motor_down after k+5. Raise gate_down_lim -> gate_closed next cycle. out_axle -> HOLD. 3 cycles later motor_up. gate_up_lim -> all outputs 0.
- Multi-axle train: 4 in_axle pulses, then 3 out_axle -> stays CLOSED, count=1. Fourth out_axle -> HOLD. An in_axle during HOLD -> back to CLOSED, count=1.
- Simultaneous events: in_axle and out_axle in the same cycle at count=2 -> count stays 2. out_axle with in_axle_rev at count 1 -> count 0, fault=1.
- Motor timeout: in LOWER, gate_down_lim is never asserted -> fault=1 exactly 10 cycles after motor_down rose, motors 0. fault_clr with count=1 -> motor_down=1.
- Re-entry while raising: in RAISE, in_axle pulse -> motor_up drops and motor_down rises on the following cycle, with no WARN phase.
- Limit conflict and reset: both limits high in CLOSED -> fault next cycle. Reset asserted in LOWER -> after one edge all outputs 0, axle_count 0.

Source files
------------

// File: rtl/lc_pkg.sv
// Shared definitions for the level crossing sequencer: state encodings and
// the timer width helper.
package lc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARN   = 3'd1,
        ST_LOWER  = 3'd2,
        ST_CLOSED = 3'd3,
        ST_HOLD   = 3'd4,
        ST_RAISE  = 3'd5,
        ST_FAULT  = 3'd6
    } lc_state_e;

    // Bits needed to hold (largest cycle count - 1), never less than one.
    function automatic int unsigned lc_timer_width(input int unsigned a,
                                                   input int unsigned b,
                                                   input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return ($clog2(m) > 0) ? int'($clog2(m)) : 1;
    endfunction

endpackage

// File: rtl/lc_timer.sv
// Loadable down-counter shared by all timed sequencer states; done_c is high
// while the count reads zero.
module lc_timer #(
    parameter int unsigned TW = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          load,
    input  logic          dec,
    input  logic [TW-1:0] load_val,
    output logic          done_c
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/level_crossing_ctrl.sv
// Level crossing sequencer: net axle count for the protected section, lamp and
// barrier motor sequencing, limit-switch/timeout supervision, latched fault.
module level_crossing_ctrl
    import lc_pkg::*;
#(
    parameter int unsigned CW            = 8,
    parameter int unsigned WARN_CYCLES   = 500,
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned MOTOR_TIMEOUT = 2000
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          in_axle,
    input  logic          in_axle_rev,
    input  logic          out_axle,
    input  logic          gate_down_lim,
    input  logic          gate_up_lim,
    input  logic          fault_clr,
    output logic          lamp_on,
    output logic          motor_down,
    output logic          motor_up,
    output logic          gate_closed,
    output logic          fault,
    output logic [CW-1:0] axle_count
);

    localparam int unsigned TW = lc_timer_width(WARN_CYCLES, HOLD_CYCLES, MOTOR_TIMEOUT);
    localparam int unsigned NW = CW + 2;
    localparam logic [TW-1:0] WARN_LOAD  = TW'(WARN_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] MOTOR_LOAD = TW'(MOTOR_TIMEOUT - 1);

    lc_state_e     state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          lamp_on_q, lamp_on_d;
    logic          motor_down_q, motor_down_d;
    logic          motor_up_q, motor_up_d;
    logic          gate_closed_q, gate_closed_d;
    logic          fault_q, fault_d;

    logic [NW-1:0] net;
    logic          cnt_ovf, cnt_unf;
    logic          tmr_load, tmr_done;
    logic [TW-1:0] tmr_val;
    logic          occupied;

    lc_timer #(.TW(TW)) u_timer (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (tmr_load),
        .dec      (1'b1),
        .load_val (tmr_val),
        .done_c   (tmr_done)
    );

    // Net axle change in two extra bits: MSB flags underflow, bit CW overflow.
    always_comb begin
        net     = NW'(count_q) + NW'(in_axle) - NW'(out_axle) - NW'(in_axle_rev);
        cnt_unf = net[NW-1];
        cnt_ovf = ~net[NW-1] & net[CW];
        count_d = net[CW-1:0];
        if (cnt_unf) begin
            count_d = '0;
        end else if (cnt_ovf) begin
            count_d = '1;
        end
    end

    assign occupied = (count_q != '0);

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = MOTOR_LOAD;
        if ((state_q != ST_FAULT) && gate_down_lim && gate_up_lim) begin
            state_d = ST_FAULT;
        end else if (cnt_ovf || cnt_unf) begin
            state_d = ST_FAULT;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (occupied) begin
                        state_d  = ST_WARN;
                        tmr_load = 1'b1;
                        tmr_val  = WARN_LOAD;
                    end
                end
                ST_WARN: begin
                    if (tmr_done) begin
                        state_d  = ST_LOWER;
                        tmr_load = 1'b1;
                    end
                end
                ST_LOWER: begin
                    if (gate_down_lim) begin
                        state_d = ST_CLOSED;
                    end else if (tmr_done) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_CLOSED: begin
                    if (!occupied) begin
                        state_d  = ST_HOLD;
                        tmr_load = 1'b1;
                        tmr_val  = HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (occupied) begin
                        state_d = ST_CLOSED;
                    end else if (tmr_done) begin
                        state_d  = ST_RAISE;
                        tmr_load = 1'b1;
                    end
                end
                ST_RAISE: begin
                    // A train arriving mid-raise reverses straight to lowering.
                    if (occupied) begin
                        state_d  = ST_LOWER;
                        tmr_load = 1'b1;
                    end else if (gate_up_lim) begin
                        state_d = ST_IDLE;
                    end else if (tmr_done) begin
                        state_d = ST_FAULT;
                    end
                end
                ST_FAULT: begin
                    if (fault_clr) begin
                        state_d  = occupied ? ST_LOWER : ST_RAISE;
                        tmr_load = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they flop alongside it.
    always_comb begin
        lamp_on_d     = (state_d != ST_IDLE);
        motor_down_d  = (state_d == ST_LOWER);
        motor_up_d    = (state_d == ST_RAISE);
        gate_closed_d = (state_d == ST_CLOSED) || (state_d == ST_HOLD);
        fault_d       = (state_d == ST_FAULT);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            lamp_on_q     <= 1'b0;
            motor_down_q  <= 1'b0;
            motor_up_q    <= 1'b0;
            gate_closed_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            lamp_on_q     <= lamp_on_d;
            motor_down_q  <= motor_down_d;
            motor_up_q    <= motor_up_d;
            gate_closed_q <= gate_closed_d;
            fault_q       <= fault_d;
        end
    end

    assign lamp_on     = lamp_on_q;
    assign motor_down  = motor_down_q;
    assign motor_up    = motor_up_q;
    assign gate_closed = gate_closed_q;
    assign fault       = fault_q;
    assign axle_count  = count_q;

endmodule

// File: tb/tb_level_crossing_ctrl.sv
// Bench for level_crossing_ctrl: directed scenarios then random traffic, all
// checked against a phase/elapsed-time model of the crossing.
module tb_level_crossing_ctrl;

    localparam int unsigned CW = 3;
    localparam int unsigned WC = 4;
    localparam int unsigned HC = 3;
    localparam int unsigned MT = 10;
    localparam int MAXC = (1 << CW) - 1;

    localparam int P_IDLE = 0, P_WARN = 1, P_LOWER = 2, P_CLOSED = 3;
    localparam int P_HOLD = 4, P_RAISE = 5, P_FAULT = 6;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          in_axle = 1'b0, in_axle_rev = 1'b0, out_axle = 1'b0;
    logic          gate_down_lim = 1'b0, gate_up_lim = 1'b1, fault_clr = 1'b0;
    logic          lamp_on, motor_down, motor_up, gate_closed, fault;
    logic [CW-1:0] axle_count;

    int n_pass = 0;
    int n_tot  = 0;
    int m_cnt  = 0;
    int m_ph   = P_IDLE;
    int m_age  = 0;

    always #5 Clk = ~Clk;

    level_crossing_ctrl #(
        .CW(CW), .WARN_CYCLES(WC), .HOLD_CYCLES(HC), .MOTOR_TIMEOUT(MT)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .in_axle(in_axle), .in_axle_rev(in_axle_rev), .out_axle(out_axle),
        .gate_down_lim(gate_down_lim), .gate_up_lim(gate_up_lim),
        .fault_clr(fault_clr),
        .lamp_on(lamp_on), .motor_down(motor_down), .motor_up(motor_up),
        .gate_closed(gate_closed), .fault(fault), .axle_count(axle_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Crossing behaviour in terms of phase and cycles spent in the phase.
    task automatic model_step();
        int net, nph;
        bit expired;
        if (Reset) begin
            m_cnt = 0; m_ph = P_IDLE; m_age = 0;
            return;
        end
        net = m_cnt + int'(in_axle) - int'(out_axle) - int'(in_axle_rev);
        nph = m_ph;
        expired = 1'b0;
        case (m_ph)
            P_WARN:                   expired = (m_age == int'(WC) - 1);
            P_HOLD:                   expired = (m_age == int'(HC) - 1);
            P_LOWER, P_RAISE:         expired = (m_age == int'(MT) - 1);
            default:                  expired = 1'b0;
        endcase
        if (m_ph != P_FAULT && gate_down_lim && gate_up_lim) nph = P_FAULT;
        else if (net < 0 || net > MAXC)                      nph = P_FAULT;
        else begin
            case (m_ph)
                P_IDLE:   if (m_cnt != 0) nph = P_WARN;
                P_WARN:   if (expired) nph = P_LOWER;
                P_LOWER:  if (gate_down_lim) nph = P_CLOSED; else if (expired) nph = P_FAULT;
                P_CLOSED: if (m_cnt == 0) nph = P_HOLD;
                P_HOLD:   if (m_cnt != 0) nph = P_CLOSED; else if (expired) nph = P_RAISE;
                P_RAISE:  if (m_cnt != 0) nph = P_LOWER;
                          else if (gate_up_lim) nph = P_IDLE;
                          else if (expired) nph = P_FAULT;
                default:  if (fault_clr) nph = (m_cnt != 0) ? P_LOWER : P_RAISE;
            endcase
        end
        m_cnt = (net < 0) ? 0 : (net > MAXC) ? MAXC : net;
        m_age = (nph != m_ph) ? 0 : m_age + 1;
        m_ph  = nph;
    endtask

    task automatic check_model();
        chk("m_count", 32'(axle_count), 32'(m_cnt));
        chk("m_lamp", 32'(lamp_on), 32'(m_ph != P_IDLE));
        chk("m_mdown", 32'(motor_down), 32'(m_ph == P_LOWER));
        chk("m_mup", 32'(motor_up), 32'(m_ph == P_RAISE));
        chk("m_closed", 32'(gate_closed), 32'(m_ph == P_CLOSED || m_ph == P_HOLD));
        chk("m_fault", 32'(fault), 32'(m_ph == P_FAULT));
        chk("motor_excl", 32'(motor_down & motor_up), 32'(0));
    endtask

    task automatic tick(input logic ia = 1'b0, input logic rev = 1'b0,
                        input logic oa = 1'b0, input logic fc = 1'b0,
                        input logic rst = 1'b0);
        @(negedge Clk);
        in_axle = ia; in_axle_rev = rev; out_axle = oa; fault_clr = fc; Reset = rst;
        @(posedge Clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, 32'({lamp_on, motor_down, motor_up, gate_closed, fault}), 32'(0));
        chk({tag, "_count"}, 32'(axle_count), 32'(0));
    endtask

    initial begin
        // Reset state
        tick(.rst(1'b1)); tick(.rst(1'b1));
        chk_all_zero("reset");

        // Normal pass
        tick(.ia(1'b1)); chk("t1_count", 32'(axle_count), 1); chk("t1_lamp0", 32'(lamp_on), 0);
        tick(); chk("t1_lamp1", 32'(lamp_on), 1);
        repeat (3) tick(); chk("t1_warn_md", 32'(motor_down), 0);
        tick(); chk("t1_lower_md", 32'(motor_down), 1);
        gate_up_lim = 1'b0; gate_down_lim = 1'b1;
        tick(); chk("t1_closed", 32'(gate_closed), 1);
        tick(.oa(1'b1)); chk("t1_out_cnt", 32'(axle_count), 0);
        tick(); tick(); tick(); chk("t1_hold_mu", 32'(motor_up), 0);
        tick(); chk("t1_raise_mu", 32'(motor_up), 1);
        gate_down_lim = 1'b0;
        tick(); chk("t1_raising", 32'(motor_up), 1);
        gate_up_lim = 1'b1;
        tick(); chk_all_zero("t1_idle");

        // Multi-axle train
        repeat (4) tick(.ia(1'b1)); chk("t2_cnt4", 32'(axle_count), 4);
        tick(); chk("t2_warn", 32'(motor_down), 0);
        tick(); chk("t2_lower", 32'(motor_down), 1);
        gate_up_lim = 1'b0; gate_down_lim = 1'b1;
        tick(); chk("t2_closed", 32'(gate_closed), 1);
        repeat (3) tick(.oa(1'b1)); chk("t2_cnt1", 32'(axle_count), 1);
        tick(); chk("t2_still_closed", 32'(gate_closed), 1);
        tick(.oa(1'b1)); tick(); tick(.ia(1'b1)); chk("t2_reenter_cnt", 32'(axle_count), 1);
        repeat (5) tick(); chk("t2_no_raise", 32'(motor_up), 0);
        chk("t2_closed_again", 32'(gate_closed), 1);

        // Simultaneous events
        tick(.ia(1'b1)); chk("t3_cnt2", 32'(axle_count), 2);
        tick(.ia(1'b1), .oa(1'b1)); chk("t3_cnt_same", 32'(axle_count), 2);
        tick(.oa(1'b1));
        tick(.oa(1'b1), .rev(1'b1)); chk("t3_unf_cnt", 32'(axle_count), 0);
        chk("t3_unf_fault", 32'(fault), 1);

        // Motor timeout
        tick(.rst(1'b1)); gate_down_lim = 1'b0; gate_up_lim = 1'b1;
        tick(.ia(1'b1)); repeat (5) tick(); chk("t4_md", 32'(motor_down), 1);
        gate_up_lim = 1'b0;
        repeat (9) tick(); chk("t4_pre_fault", 32'(fault), 0);
        tick(); chk("t4_fault", 32'(fault), 1); chk("t4_motors", 32'({motor_down, motor_up}), 0);
        tick(.fc(1'b1)); chk("t4_clr_md", 32'(motor_down), 1);
        gate_down_lim = 1'b1;
        tick(); chk("t4_closed", 32'(gate_closed), 1);

        // Re-entry while raising
        tick(.oa(1'b1)); tick(); tick(); tick(); chk("t5_hold", 32'(motor_up), 0);
        tick(); chk("t5_raise", 32'(motor_up), 1);
        gate_down_lim = 1'b0;
        tick(.ia(1'b1)); chk("t5_still_up", 32'(motor_up), 1);
        tick(); chk("t5_rev_mu", 32'(motor_up), 0); chk("t5_rev_md", 32'(motor_down), 1);
        gate_down_lim = 1'b1;
        tick(); chk("t5_closed", 32'(gate_closed), 1);

        // Limit conflict, then reset during LOWER
        gate_up_lim = 1'b1;
        tick(); chk("t6_conflict", 32'(fault), 1);
        gate_up_lim = 1'b0;
        tick(.fc(1'b1)); chk("t6_lower", 32'(motor_down), 1);
        tick(.rst(1'b1)); chk_all_zero("t6_reset");
        gate_down_lim = 1'b0; gate_up_lim = 1'b1;

        // Counter overflow
        repeat (MAXC) tick(.ia(1'b1)); chk("t7_max", 32'(axle_count), 32'(MAXC));
        tick(.ia(1'b1)); chk("t7_hold_max", 32'(axle_count), 32'(MAXC));
        chk("t7_ovf_fault", 32'(fault), 1);
        tick(.rst(1'b1));

        // Random traffic with plausible barrier sensors
        for (int i = 0; i < 4000; i++) begin
            tick(.ia($urandom_range(9) == 0), .rev($urandom_range(29) == 0),
                 .oa($urandom_range(8) == 0), .fc($urandom_range(39) == 0),
                 .rst($urandom_range(499) == 0));
            if (gate_down_lim && gate_up_lim) gate_up_lim = 1'b0;
            if (motor_down && $urandom_range(5) == 0) begin gate_down_lim = 1'b1; gate_up_lim = 1'b0; end
            if (motor_up && $urandom_range(5) == 0) begin gate_up_lim = 1'b1; gate_down_lim = 1'b0; end
            if ($urandom_range(299) == 0) begin gate_down_lim = 1'b1; gate_up_lim = 1'b1; end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
